// File: rtl/fmrv32im_plic_v2.sv
`default_nettype none
// ============================================================================
// Module   : fmrv32im_plic_v2
// Brief    : Small fixed-priority interrupt controller for the fmrv32im core.
//            Per-source edge/level capture, enable mask, claim/complete
//            handshake with in-service tracking, registered INT_OUT.
//            Optional macro FMRV32IM_PLIC_SYNC_EN adds a two-flop input
//            synchroniser ahead of the sampling register (+2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module fmrv32im_plic_v2 #(
  parameter int NUM_SRC = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               BUS_WE,
  input  logic               BUS_RE,
  input  logic [3:0]         BUS_ADDR,
  input  logic [31:0]        BUS_WDATA,
  output logic [31:0]        BUS_RDATA,
  input  logic [NUM_SRC-1:0] INT_IN,
  output logic               INT_OUT
);

  localparam logic [3:0]  c_ADDR_PENDING = 4'h0;
  localparam logic [3:0]  c_ADDR_ENABLE  = 4'h1;
  localparam logic [3:0]  c_ADDR_MODE    = 4'h2;
  localparam logic [3:0]  c_ADDR_CLAIM   = 4'h3;
  localparam logic [3:0]  c_ADDR_INSVC   = 4'h4;
  // Bits at or above NUM_SRC are forced to zero everywhere.
  localparam logic [31:0] c_SRC_MASK =
    (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_SRC) - 32'd1);

  logic [31:0] w_int_in32;
  logic [31:0] w_in_src;
  logic [31:0] r_s_in;
  logic [31:0] r_s_prev;
  logic [31:0] r_pending;
  logic [31:0] r_enable;
  logic [31:0] r_mode;
  logic [31:0] r_insvc;
  logic        r_int_out;

  logic        w_wr_pending;
  logic        w_wr_enable;
  logic        w_wr_mode;
  logic        w_wr_claim;
  logic        w_rd_claim;
  logic        w_claim_fire;
  logic [31:0] w_rise;
  logic [31:0] w_cand;
  logic [5:0]  w_claim_id;
  logic [31:0] w_claim_onehot;
  logic [31:0] w_claim_set;
  logic [31:0] w_cmp_onehot;
  logic [31:0] w_mode_next;
  logic [31:0] w_to_edge;
  logic [31:0] w_edge_clr;
  logic [31:0] w_pend_held;
  logic [31:0] w_pend_next;
  logic [31:0] w_insvc_next;

  // Widen the request lines to the full 32-bit register width.
  generate
    if (NUM_SRC >= 32) begin : g_in_full
      assign w_int_in32 = INT_IN;
    end else begin : g_in_pad
      assign w_int_in32 = {{(32-NUM_SRC){1'b0}}, INT_IN};
    end
  endgenerate

`ifdef FMRV32IM_PLIC_SYNC_EN
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;

  // Two-flop synchroniser for asynchronous request lines.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 32'd0;
      r_sync2 <= 32'd0;
    end else begin
      r_sync1 <= w_int_in32;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in_src = r_sync2;
`else
  assign w_in_src = w_int_in32;
`endif

  // Bus decode.
  assign w_wr_pending = BUS_WE && (BUS_ADDR == c_ADDR_PENDING);
  assign w_wr_enable  = BUS_WE && (BUS_ADDR == c_ADDR_ENABLE);
  assign w_wr_mode    = BUS_WE && (BUS_ADDR == c_ADDR_MODE);
  assign w_wr_claim   = BUS_WE && (BUS_ADDR == c_ADDR_CLAIM);
  assign w_rd_claim   = BUS_RE && (BUS_ADDR == c_ADDR_CLAIM);

  assign w_rise = r_s_in & ~r_s_prev & c_SRC_MASK;
  assign w_cand = r_pending & r_enable & ~r_insvc;

  // Fixed priority encoder: the loop runs high to low so the lowest index wins.
  always_comb begin
    w_claim_id     = 6'd0;
    w_claim_onehot = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_claim_id     = 6'(i + 1);
        w_claim_onehot = 32'd1 << i;
      end
    end
  end

  // Decode the completion ID written to CLAIM; out-of-range IDs decode to nothing.
  always_comb begin
    w_cmp_onehot = 32'd0;
    for (int i = 0; i < 32; i++) begin
      w_cmp_onehot[i] = w_wr_claim && (BUS_WDATA == 32'(i + 1));
    end
    w_cmp_onehot = w_cmp_onehot & c_SRC_MASK;
  end

  assign w_claim_fire = w_rd_claim && (w_claim_id != 6'd0);
  assign w_claim_set  = w_claim_fire ? w_claim_onehot : 32'd0;

  // A bit moving from level to edge keeps only a genuine rising edge, so a
  // line already high does not leave a stale pending bit behind.
  assign w_mode_next = w_wr_mode ? (BUS_WDATA & c_SRC_MASK) : r_mode;
  assign w_to_edge   = w_mode_next & ~r_mode;

  // W1C and claim clear only edge sources; a simultaneous rising edge wins.
  assign w_edge_clr  = ((w_wr_pending ? BUS_WDATA : 32'd0) | w_claim_set) & r_mode;
  assign w_pend_held = (r_pending & ~w_edge_clr) | w_rise;
  assign w_pend_next = ((w_to_edge & w_rise) |
                        (~w_to_edge & ((r_mode & w_pend_held) | (~r_mode & r_s_in))))
                       & c_SRC_MASK;

  // Claim sets in-service; a matching complete clears it.
  assign w_insvc_next = ((r_insvc & ~w_cmp_onehot) | w_claim_set) & c_SRC_MASK;

  // Input sampling and edge history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s_in   <= 32'd0;
      r_s_prev <= 32'd0;
    end else begin
      r_s_in   <= w_in_src & c_SRC_MASK;
      r_s_prev <= r_s_in;
    end
  end

  // Controller state: pending, enable, mode, in-service and the request output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= 32'd0;
      r_enable  <= 32'd0;
      r_mode    <= 32'd0;
      r_insvc   <= 32'd0;
      r_int_out <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      r_mode    <= w_mode_next;
      r_insvc   <= w_insvc_next;
      r_int_out <= |w_cand;
      if (w_wr_enable) begin
        r_enable <= BUS_WDATA & c_SRC_MASK;
      end
    end
  end

  assign INT_OUT = r_int_out;

  // Combinational read mux.
  always_comb begin
    BUS_RDATA = 32'd0;
    case (BUS_ADDR)
      c_ADDR_PENDING: BUS_RDATA = r_pending;
      c_ADDR_ENABLE:  BUS_RDATA = r_enable;
      c_ADDR_MODE:    BUS_RDATA = r_mode;
      c_ADDR_CLAIM:   BUS_RDATA = {26'd0, w_claim_id};
      c_ADDR_INSVC:   BUS_RDATA = r_insvc;
      default:        BUS_RDATA = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
